booth_mac_ctrl: RTL and testbench

- Sequencer that sits directly upstream of the 8x8 radix-2 Booth multiplier.
- Accepts a stream of signed operand pairs on a valid/ready handshake and drives the multiplier's mc/mp/start inputs.
- Monitors busy and captures the 16-bit product exactly once per term.
- Accumulates the products of one packet, delimited by in_last, and presents the sum on a valid/ready output.

---
 rtl/booth_pkg.sv | 16 +
 rtl/booth_acc_add.sv | 46 ++++
 rtl/booth_mac_ctrl.sv | 159 +++++++++++++++
 tb/tb_booth_mac_ctrl.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier MAC sequencer.
// Optional saturating accumulate is enabled with BOOTH_MAC_SAT_EN.
package booth_pkg;

    localparam int OP_W             = 8;
    localparam int PROD_W           = 16;
    localparam int WAIT_MAX_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/booth_acc_add.sv
// Sign-extends a 16-bit product to ACC_W and adds it to the accumulator.
// With BOOTH_MAC_SAT_EN the sum clips to the signed ACC_W range; ovf flags any signed overflow.
module booth_acc_add
    import booth_pkg::*;
#(
    parameter int ACC_W = 24
)(
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   wide_sum;

    assign prod_ext[PROD_W-1:0] = prod;

    genvar gi;
    generate
        for (gi = PROD_W; gi < ACC_W; gi++) begin : g_sext
            assign prod_ext[gi] = prod[PROD_W-1];
        end
    endgenerate

    // One guard bit: overflow shows up as disagreement between the top two bits.
    assign wide_sum = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
    assign ovf      = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];

`ifdef BOOTH_MAC_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    always_comb begin
        sum = wide_sum[ACC_W-1:0];
        if (ovf) begin
            sum = wide_sum[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    always_comb begin
        sum = wide_sum[ACC_W-1:0];
    end
`endif

endmodule

// File: rtl/booth_mac_ctrl.sv
// Sequencer for an 8x8 radix-2 Booth multiplier: feeds operand pairs, captures each product
// once, accumulates per packet. Define BOOTH_MAC_SAT_EN for saturating accumulate and out_sat.
module booth_mac_ctrl
    import booth_pkg::*;
#(
    parameter int ACC_W    = 24,
    parameter int CNT_W    = 8,
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_mc,
    input  logic [OP_W-1:0]   in_mp,
    input  logic              in_last,
    output logic [OP_W-1:0]   mul_mc,
    output logic [OP_W-1:0]   mul_mp,
    output logic              mul_start,
    input  logic              mul_busy,
    input  logic [PROD_W-1:0] mul_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_terms,
`ifdef BOOTH_MAC_SAT_EN
    output logic              out_sat,
`endif
    output logic              err_timeout
);

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);

    state_t            state_reg, state_next;
    logic [OP_W-1:0]   mc_reg, mp_reg;
    logic              last_reg;
    logic [WCNT_W-1:0] wait_cnt_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]  terms_reg;
    logic              err_reg;
    logic              do_accept, do_capture, do_timeout, do_release;

`ifdef BOOTH_MAC_SAT_EN
    logic              add_ovf;
    logic              sat_reg;
`else
    logic              add_ovf_unused;
`endif

    booth_acc_add #(
        .ACC_W (ACC_W)
    ) u_acc_add (
        .acc  (acc_reg),
        .prod (mul_prod),
        .sum  (acc_sum),
`ifdef BOOTH_MAC_SAT_EN
        .ovf  (add_ovf)
`else
        .ovf  (add_ovf_unused)
`endif
    );

    // busy is only trusted in WAIT: before the first start the multiplier output is undefined.
    always_comb begin
        state_next = state_reg;
        do_accept  = 1'b0;
        do_capture = 1'b0;
        do_timeout = 1'b0;
        do_release = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    do_accept  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (!mul_busy) begin
                    do_capture = 1'b1;
                    state_next = last_reg ? OUT : IDLE;
                end else if (wait_cnt_reg == WCNT_W'(WAIT_MAX - 1)) begin
                    do_timeout = 1'b1;
                    state_next = IDLE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    do_release = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            mc_reg       <= '0;
            mp_reg       <= '0;
            last_reg     <= 1'b0;
            wait_cnt_reg <= '0;
            acc_reg      <= '0;
            terms_reg    <= '0;
            err_reg      <= 1'b0;
`ifdef BOOTH_MAC_SAT_EN
            sat_reg      <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (do_accept) begin
                mc_reg   <= in_mc;
                mp_reg   <= in_mp;
                last_reg <= in_last;
            end
            if (state_reg == START) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
            if (do_capture) begin
                acc_reg   <= acc_sum;
                terms_reg <= terms_reg + 1'b1;
            end else if (do_release) begin
                acc_reg   <= '0;
                terms_reg <= '0;
            end
            if (do_timeout) begin
                err_reg <= 1'b1;
            end
`ifdef BOOTH_MAC_SAT_EN
            if (do_capture && add_ovf) begin
                sat_reg <= 1'b1;
            end else if (do_release) begin
                sat_reg <= 1'b0;
            end
`endif
        end
    end

    assign in_ready    = (state_reg == IDLE);
    assign mul_start   = (state_reg == START);
    assign out_valid   = (state_reg == OUT);
    assign mul_mc      = mc_reg;
    assign mul_mp      = mp_reg;
    assign out_acc     = acc_reg;
    assign out_terms   = terms_reg;
    assign err_timeout = err_reg;
`ifdef BOOTH_MAC_SAT_EN
    assign out_sat     = sat_reg;
`endif

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// Bench for booth_mac_ctrl: a 24-bit and a 16-bit accumulator instance run in lockstep
// behind one behavioural radix-2 Booth multiplier; results are checked against a scoreboard.
module tb_booth_mac_ctrl;

    localparam int ACC_A    = 24;
    localparam int ACC_B    = 16;
    localparam int CNT_W    = 8;
    localparam int WAIT_MAX = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid, in_last, out_ready;
    logic [7:0]       in_mc, in_mp;
    logic             in_ready_a, in_ready_b;
    logic [7:0]       mul_mc_a, mul_mp_a, mul_mc_b, mul_mp_b;
    logic             mul_start_a, mul_start_b;
    logic             mul_busy;
    logic [15:0]      mul_prod;
    logic             out_valid_a, out_valid_b;
    logic [ACC_A-1:0] out_acc_a;
    logic [ACC_B-1:0] out_acc_b;
    logic [CNT_W-1:0] out_terms_a, out_terms_b;
    logic             err_a, err_b;
`ifdef BOOTH_MAC_SAT_EN
    logic             out_sat_a, out_sat_b;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    booth_mac_ctrl #(.ACC_W(ACC_A), .CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_mc(in_mc), .in_mp(in_mp), .in_last(in_last),
        .mul_mc(mul_mc_a), .mul_mp(mul_mp_a), .mul_start(mul_start_a),
        .mul_busy(mul_busy), .mul_prod(mul_prod),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
        .out_terms(out_terms_a),
`ifdef BOOTH_MAC_SAT_EN
        .out_sat(out_sat_a),
`endif
        .err_timeout(err_a)
    );

    booth_mac_ctrl #(.ACC_W(ACC_B), .CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_mc(in_mc), .in_mp(in_mp), .in_last(in_last),
        .mul_mc(mul_mc_b), .mul_mp(mul_mp_b), .mul_start(mul_start_b),
        .mul_busy(mul_busy), .mul_prod(mul_prod),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
        .out_terms(out_terms_b),
`ifdef BOOTH_MAC_SAT_EN
        .out_sat(out_sat_b),
`endif
        .err_timeout(err_b)
    );

    // Behavioural radix-2 Booth multiplier: no reset, 9-bit A so -128 operands work,
    // keeps shifting after step 8 and re-asserts busy when its 4-bit count wraps.
    logic [3:0]        m_cnt;
    logic signed [8:0] m_a, m_m, m_sum;
    logic [7:0]        m_q;
    logic              m_q1;
    logic              force_busy;

    always_comb begin
        case ({m_q[0], m_q1})
            2'b01:   m_sum = m_a + m_m;
            2'b10:   m_sum = m_a - m_m;
            default: m_sum = m_a;
        endcase
    end

    always @(posedge clk) begin
        if (mul_start_a) begin
            m_cnt <= 4'd0;
            m_m   <= {mul_mc_a[7], mul_mc_a};
            m_a   <= '0;
            m_q   <= mul_mp_a;
            m_q1  <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 4'd1;
            m_a   <= {m_sum[8], m_sum[8:1]};
            m_q   <= {m_sum[0], m_q[7:1]};
            m_q1  <= m_q[0];
        end
    end

    assign mul_busy = force_busy | (m_cnt < 4'd8);
    assign mul_prod = {m_a[7:0], m_q};

    // Scoreboard
    typedef struct {
        longint acc_a;
        longint acc_b;
        int     terms;
        bit     sat_a;
        bit     sat_b;
    } exp_t;

    exp_t   sb_q[$];
    longint m_acc_a, m_acc_b;
    int     m_terms;
    bit     m_sat_a, m_sat_b;
    int     n_checks = 0;
    int     n_errors = 0;

    function automatic longint model_add(input longint a, input longint p, input int w, output bit clip);
        longint s, mx, mn, span;
        span = longint'(1) << w;
        mx   = (longint'(1) << (w - 1)) - 1;
        mn   = -(longint'(1) << (w - 1));
        s    = a + p;
        clip = 1'b0;
`ifdef BOOTH_MAC_SAT_EN
        if (s > mx) begin
            s = mx; clip = 1'b1;
        end else if (s < mn) begin
            s = mn; clip = 1'b1;
        end
`else
        if (s > mx) s = s - span;
        else if (s < mn) s = s + span;
`endif
        return s;
    endfunction

    task automatic model_clear();
        m_acc_a = 0; m_acc_b = 0; m_terms = 0; m_sat_a = 1'b0; m_sat_b = 1'b0;
    endtask

    task automatic model_term(input int mc, input int mp, input bit last);
        bit     c;
        longint p;
        exp_t   e;
        p = longint'(mc) * longint'(mp);
        m_acc_a = model_add(m_acc_a, p, ACC_A, c); m_sat_a = m_sat_a | c;
        m_acc_b = model_add(m_acc_b, p, ACC_B, c); m_sat_b = m_sat_b | c;
        m_terms++;
        if (last) begin
            e.acc_a = m_acc_a; e.acc_b = m_acc_b; e.terms = m_terms % 256;
            e.sat_a = m_sat_a; e.sat_b = m_sat_b;
            sb_q.push_back(e);
            model_clear();
        end
    endtask

    // Offers one pair, waits (bounded) for acceptance; returns cycles spent waiting for in_ready.
    task automatic send_term(input int mc, input int mp, input bit last, input bit track, output int waited);
        in_mc = 8'(mc); in_mp = 8'(mp); in_last = last; in_valid = 1'b1;
        waited = 0;
        while (!in_ready_a && waited < 200) begin
            @(posedge clk); #1; waited++;
        end
        n_checks++;
        if (!in_ready_a) begin
            n_errors++;
            $display("FAIL accept_wait: in_ready=%0b after %0d cycles, required 1", in_ready_a, waited);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (track) model_term(mc, mp, last);
    endtask

    task automatic wait_result(output exp_t e, output int waited);
        waited = 0;
        while (!out_valid_a && waited < 200) begin
            @(posedge clk); #1; waited++;
        end
        n_checks++;
        if (!out_valid_a || !out_valid_b) begin
            n_errors++;
            $display("FAIL result_wait: out_valid a/b=%0b/%0b after %0d cycles, required 1/1", out_valid_a, out_valid_b, waited);
        end else if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_result: out_valid=1 with empty scoreboard, required no result");
        end
        if (sb_q.size() != 0) e = sb_q.pop_front();
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_mc = '0; in_mp = '0; force_busy = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({mul_mc_a, mul_mp_a, mul_start_a, out_valid_a, out_acc_a, out_terms_a, err_a} !== '0 ||
            {mul_mc_b, mul_mp_b, mul_start_b, out_valid_b, out_acc_b, out_terms_b, err_b} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: mc=%0h mp=%0h start=%0b valid=%0b acc=%0h terms=%0d err=%0b, required all 0",
                     mul_mc_a, mul_mp_a, mul_start_a, out_valid_a, out_acc_a, out_terms_a, err_a);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_in_ready: in_ready=%0b/%0b, required 1/1", in_ready_a, in_ready_b);
        end
        $display("test_reset: done");
    endtask

    task automatic test_single();
        exp_t e;
        int   w;
        send_term(3, 5, 1'b1, 1'b1, w);
        wait_result(e, w);
        n_checks++;
        if (w !== 10) begin
            n_errors++;
            $display("FAIL single_latency: out_valid after %0d clocks past accept edge, required 10", w);
        end
        n_checks++;
        if (longint'($signed(out_acc_a)) !== e.acc_a || longint'($signed(out_acc_b)) !== e.acc_b) begin
            n_errors++;
            $display("FAIL single_acc: acc=%0d/%0d, required %0d/%0d", $signed(out_acc_a), $signed(out_acc_b), e.acc_a, e.acc_b);
        end
        n_checks++;
        if (int'(out_terms_a) !== e.terms || int'(out_terms_b) !== e.terms) begin
            n_errors++;
            $display("FAIL single_terms: terms=%0d/%0d, required %0d", out_terms_a, out_terms_b, e.terms);
        end
        $display("test_single: 3*5 acc=%0d terms=%0d", $signed(out_acc_a), out_terms_a);
        accept_result();
    endtask

    task automatic test_corner();
        exp_t e;
        int   w;
        int   mcs[2] = '{-128, -128};
        int   mps[2] = '{-128, 127};
        for (int i = 0; i < 2; i++) begin
            send_term(mcs[i], mps[i], 1'b1, 1'b1, w);
            wait_result(e, w);
            n_checks++;
            if (longint'($signed(out_acc_a)) !== e.acc_a || longint'($signed(out_acc_b)) !== e.acc_b) begin
                n_errors++;
                $display("FAIL corner_acc[%0d]: acc=%0d/%0d, required %0d/%0d", i, $signed(out_acc_a), $signed(out_acc_b), e.acc_a, e.acc_b);
            end
            n_checks++;
            if (mul_mc_a !== 8'(mcs[i]) || mul_mp_a !== 8'(mps[i])) begin
                n_errors++;
                $display("FAIL corner_operand_hold[%0d]: mul_mc=%0h mul_mp=%0h, required %0h %0h", i, mul_mc_a, mul_mp_a, 8'(mcs[i]), 8'(mps[i]));
            end
            $display("test_corner: %0d*%0d acc=%0d", mcs[i], mps[i], $signed(out_acc_a));
            accept_result();
        end
    endtask

    task automatic test_two_term();
        exp_t e;
        int   w;
        send_term(100, 100, 1'b0, 1'b1, w);
        send_term(-50, 3, 1'b1, 1'b1, w);
        n_checks++;
        if (w !== 10) begin
            n_errors++;
            $display("FAIL two_term_throughput: second accept waited %0d clocks, required 10", w);
        end
        wait_result(e, w);
        n_checks++;
        if (longint'($signed(out_acc_a)) !== e.acc_a || longint'($signed(out_acc_b)) !== e.acc_b) begin
            n_errors++;
            $display("FAIL two_term_acc: acc=%0d/%0d, required %0d/%0d", $signed(out_acc_a), $signed(out_acc_b), e.acc_a, e.acc_b);
        end
        n_checks++;
        if (int'(out_terms_a) !== e.terms || int'(out_terms_b) !== e.terms) begin
            n_errors++;
            $display("FAIL two_term_terms: terms=%0d/%0d, required %0d", out_terms_a, out_terms_b, e.terms);
        end
        $display("test_two_term: acc=%0d terms=%0d", $signed(out_acc_a), out_terms_a);
        accept_result();
        n_checks++;
        if (out_acc_a !== '0 || out_terms_a !== '0 || out_acc_b !== '0) begin
            n_errors++;
            $display("FAIL two_term_clear: acc=%0d terms=%0d after accept, required 0 0", $signed(out_acc_a), out_terms_a);
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        int   w;
        for (int i = 0; i < 3; i++) send_term(127, 127, (i == 2), 1'b1, w);
        wait_result(e, w);
        n_checks++;
        if (longint'($signed(out_acc_a)) !== e.acc_a || longint'($signed(out_acc_b)) !== e.acc_b) begin
            n_errors++;
            $display("FAIL overflow_acc: acc=%0d/%0d, required %0d/%0d", $signed(out_acc_a), $signed(out_acc_b), e.acc_a, e.acc_b);
        end
`ifdef BOOTH_MAC_SAT_EN
        n_checks++;
        if (out_sat_a !== e.sat_a || out_sat_b !== e.sat_b) begin
            n_errors++;
            $display("FAIL overflow_sat: out_sat=%0b/%0b, required %0b/%0b", out_sat_a, out_sat_b, e.sat_a, e.sat_b);
        end
`endif
        $display("test_overflow: 3x(127*127) acc24=%0d acc16=%0d", $signed(out_acc_a), $signed(out_acc_b));
        accept_result();
`ifdef BOOTH_MAC_SAT_EN
        n_checks++;
        if (out_sat_b !== 1'b0) begin
            n_errors++;
            $display("FAIL overflow_sat_clear: out_sat=%0b after accept, required 0", out_sat_b);
        end
`endif
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   w;
        send_term(7, -9, 1'b1, 1'b1, w);
        wait_result(e, w);
        in_mc = 8'd1; in_mp = 8'd2; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid_a !== 1'b1 || longint'($signed(out_acc_a)) !== e.acc_a ||
                int'(out_terms_a) !== e.terms || in_ready_a !== 1'b0) begin
                n_errors++;
                $display("FAIL backpressure_hold[%0d]: valid=%0b acc=%0d terms=%0d in_ready=%0b, required 1 %0d %0d 0",
                         i, out_valid_a, $signed(out_acc_a), out_terms_a, in_ready_a, e.acc_a, e.terms);
            end
        end
        accept_result();
        n_checks++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
            n_errors++;
            $display("FAIL backpressure_release: in_ready=%0b out_valid=%0b, required 1 0", in_ready_a, out_valid_a);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_term(1, 2, 1'b1);
        n_checks++;
        if (mul_mc_a !== 8'd1 || mul_mp_a !== 8'd2) begin
            n_errors++;
            $display("FAIL backpressure_stalled_pair: mul_mc=%0d mul_mp=%0d, required 1 2", mul_mc_a, mul_mp_a);
        end
        wait_result(e, w);
        n_checks++;
        if (longint'($signed(out_acc_a)) !== e.acc_a || longint'($signed(out_acc_b)) !== e.acc_b) begin
            n_errors++;
            $display("FAIL backpressure_acc: acc=%0d/%0d, required %0d/%0d", $signed(out_acc_a), $signed(out_acc_b), e.acc_a, e.acc_b);
        end
        $display("test_backpressure: stalled pair acc=%0d", $signed(out_acc_a));
        accept_result();
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        int   w;
        send_term(10, 10, 1'b0, 1'b1, w);
        send_term(6, 6, 1'b1, 1'b0, w);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mul_mc_a, mul_mp_a, mul_start_a, out_valid_a, out_acc_a, out_terms_a, err_a} !== '0 ||
            {out_acc_b, out_terms_b} !== '0) begin
            n_errors++;
            $display("FAIL midwait_reset_outputs: mc=%0h mp=%0h start=%0b valid=%0b acc=%0d terms=%0d err=%0b, required all 0",
                     mul_mc_a, mul_mp_a, mul_start_a, out_valid_a, $signed(out_acc_a), out_terms_a, err_a);
        end
        model_clear();
        sb_q.delete();
        @(negedge clk); rst_n = 1'b1;
        send_term(2, -7, 1'b1, 1'b1, w);
        wait_result(e, w);
        n_checks++;
        if (longint'($signed(out_acc_a)) !== e.acc_a || int'(out_terms_a) !== e.terms) begin
            n_errors++;
            $display("FAIL midwait_new_packet: acc=%0d terms=%0d, required %0d %0d", $signed(out_acc_a), out_terms_a, e.acc_a, e.terms);
        end
        $display("test_reset_mid_wait: new packet acc=%0d", $signed(out_acc_a));
        accept_result();
    endtask

    task automatic test_timeout();
        exp_t e;
        int   w;
        int   cyc;
        force_busy = 1'b1;
        send_term(1, 1, 1'b1, 1'b0, w);
        cyc = 0;
        while (!err_a && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        n_checks++;
        if (cyc !== WAIT_MAX + 1 || err_b !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_cycles: err_timeout after %0d clocks (b=%0b), required %0d", cyc, err_b, WAIT_MAX + 1);
        end
        n_checks++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_idle: in_ready=%0b out_valid=%0b, required 1 0", in_ready_a, out_valid_a);
        end
        force_busy = 1'b0;
        send_term(4, 5, 1'b1, 1'b1, w);
        wait_result(e, w);
        n_checks++;
        if (longint'($signed(out_acc_a)) !== e.acc_a || err_a !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_recover: acc=%0d err=%0b, required %0d 1", $signed(out_acc_a), err_a, e.acc_a);
        end
        $display("test_timeout: after timeout acc=%0d err=%0b", $signed(out_acc_a), err_a);
        accept_result();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (err_a !== 1'b0 || err_b !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_reset_clear: err_timeout=%0b/%0b, required 0/0", err_a, err_b);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_corner();
        test_two_term();
        test_overflow();
        test_backpressure();
        test_reset_mid_wait();
        test_timeout();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
